// File: rtl/updi_uart_tx.sv
// UPDI frame serialiser: start, 8 data bits LSB first, even parity, two stop bits.
// Owns the line mux so an active break from updi_double_break always wins the wire.
module updi_uart_tx #(
  parameter int BIT_CLK = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       brk_busy,
  input  logic       brk_line,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  localparam int CW = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          bit_end;
  logic          frame_lvl;

  // Handshake: a byte is taken on a rising edge where valid && ready.
  // ready is combinational and drops the moment a break claims the line.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    bit_end   = (cnt_q == CNT_LAST);
    ready     = (state_q == S_IDLE) && !brk_busy;
    frame_lvl = 1'b1;

    if (state_q != S_IDLE && brk_busy) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      abort_d = 1'b1;
    end else begin
      if (state_q != S_IDLE) begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (valid && ready) begin
            shift_d = data_in;
            par_d   = ^data_in;
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
        S_START: begin
          if (bit_end) state_d = S_DATA;
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_d = S_PARITY;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_d = S_STOP;
            bit_d   = '0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_q == 3'd1) begin
              state_d = S_IDLE;
              bit_d   = '0;
              done_d  = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    case (state_q)
      S_START:  frame_lvl = 1'b0;
      S_DATA:   frame_lvl = shift_q[bit_q];
      S_PARITY: frame_lvl = par_q;
      default:  frame_lvl = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign tx    = brk_busy ? brk_line : frame_lvl;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_updi_uart_tx.sv
// Directed bench for updi_uart_tx at BIT_CLK=10: frame bit patterns, handshake,
// back-to-back frames, break abort and asynchronous reset mid-frame.
module tb_updi_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       brk_busy;
  logic       brk_line;
  logic       tx;
  logic       busy;
  logic       done;
  logic       abort;

  int total = 0;
  int bad   = 0;

  updi_uart_tx #(.BIT_CLK(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid    (valid),
    .ready    (ready),
    .brk_busy (brk_busy),
    .brk_line (brk_line),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .abort    (abort)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at the negedge
  // of the done cycle. f[i] is the expected line level of frame bit i.
  task automatic run_frame(input string tag, input logic [11:0] f);
    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < 10; c++) begin
        check($sformatf("%s_tx_b%0d_c%0d", tag, b, c), {7'd0, tx}, {7'd0, f[b]});
        check($sformatf("%s_busy_b%0d_c%0d", tag, b, c), {7'd0, busy}, 8'd1);
        check($sformatf("%s_done_b%0d_c%0d", tag, b, c), {7'd0, done}, 8'd0);
        if (c == 0) check($sformatf("%s_ready_b%0d", tag, b), {7'd0, ready}, 8'd0);
        @(negedge clk);
      end
    end
    check({tag, "_done_pulse"}, {7'd0, done}, 8'd1);
    check({tag, "_done_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_done_tx"}, {7'd0, tx}, 8'd1);
    check({tag, "_done_abort"}, {7'd0, abort}, 8'd0);
  endtask

  // Driver: present a byte at a negedge, let the next rising edge accept it.
  task automatic accept_byte(input logic [7:0] d);
    data_in = d;
    valid   = 1'b1;
    check("acc_ready", {7'd0, ready}, 8'd1);
    @(negedge clk);
    data_in = ~d;
  endtask

  initial begin
    rst      = 1'b1;
    data_in  = 8'h00;
    valid    = 1'b0;
    brk_busy = 1'b0;
    brk_line = 1'b1;

    // Reset held
    #1;
    check("rst_tx", {7'd0, tx}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_abort", {7'd0, abort}, 8'd0);
    check("rst_ready", {7'd0, ready}, 8'd1);
    cycles(3);
    rst = 1'b0;
    cycles(2);
    check("post_rst_tx", {7'd0, tx}, 8'd1);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    check("post_rst_ready", {7'd0, ready}, 8'd1);

    // 0x55: 0,1,0,1,0,1,0,1,0, parity 0, 1, 1
    accept_byte(8'h55);
    valid = 1'b0;
    run_frame("f55", 12'b110010101010);
    @(negedge clk);
    check("f55_done_one_cycle", {7'd0, done}, 8'd0);
    check("f55_idle_ready", {7'd0, ready}, 8'd1);

    // 0x01: data[0]=1, rest 0, parity 1
    accept_byte(8'h01);
    valid = 1'b0;
    run_frame("f01", 12'b111000000010);
    cycles(3);

    // Back-to-back 0xC6 (parity 0) then 0x80 (parity 1), valid held
    accept_byte(8'hC6);
    data_in = 8'h80;
    run_frame("fc6", 12'b110110001100);
    check("b2b_ready_in_done", {7'd0, ready}, 8'd1);
    @(negedge clk);
    valid = 1'b0;
    run_frame("f80", 12'b111100000000);
    cycles(3);

    // Break during data bit 3 of 0xFF (cycles 41..50 after accept)
    accept_byte(8'hFF);
    valid = 1'b0;
    cycles(44);
    check("brk_pre_tx", {7'd0, tx}, 8'd1);
    check("brk_pre_busy", {7'd0, busy}, 8'd1);
    brk_busy = 1'b1;
    brk_line = 1'b0;
    #1;
    check("brk_tx_same_cycle", {7'd0, tx}, 8'd0);
    check("brk_ready_drop", {7'd0, ready}, 8'd0);
    check("brk_abort_not_yet", {7'd0, abort}, 8'd0);
    @(negedge clk);
    check("brk_abort_pulse", {7'd0, abort}, 8'd1);
    check("brk_busy_clear", {7'd0, busy}, 8'd0);
    check("brk_no_done", {7'd0, done}, 8'd0);
    check("brk_tx_follow", {7'd0, tx}, 8'd0);
    valid   = 1'b1;
    data_in = 8'h33;
    @(negedge clk);
    check("brk_abort_one_cycle", {7'd0, abort}, 8'd0);
    brk_line = 1'b1;
    #1;
    check("brk_tx_follow_hi", {7'd0, tx}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("brk_hold_ready_%0d", i), {7'd0, ready}, 8'd0);
      check($sformatf("brk_hold_busy_%0d", i), {7'd0, busy}, 8'd0);
    end
    valid    = 1'b0;
    brk_busy = 1'b0;
    #1;
    check("brk_release_ready", {7'd0, ready}, 8'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("brk_after_done_%0d", i), {7'd0, done}, 8'd0);
      check($sformatf("brk_after_tx_%0d", i), {7'd0, tx}, 8'd1);
    end

    // Asynchronous reset during the parity bit (cycles 91..100)
    accept_byte(8'h55);
    valid = 1'b0;
    cycles(94);
    check("ar_pre_busy", {7'd0, busy}, 8'd1);
    check("ar_pre_tx_parity", {7'd0, tx}, 8'd0);
    rst = 1'b1;
    #1;
    check("ar_tx", {7'd0, tx}, 8'd1);
    check("ar_busy", {7'd0, busy}, 8'd0);
    check("ar_done", {7'd0, done}, 8'd0);
    check("ar_abort", {7'd0, abort}, 8'd0);
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("ar_after_done_%0d", i), {7'd0, done}, 8'd0);
      check($sformatf("ar_after_abort_%0d", i), {7'd0, abort}, 8'd0);
    end
    accept_byte(8'h55);
    valid = 1'b0;
    run_frame("ar55", 12'b110010101010);
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updi_uart_tx.md
Name: updi_uart_tx

Overview:
- Serialises bytes into UPDI frames on the single-wire UPDI line, downstream of the link controller.
- Sits alongside updi_double_break and owns the line mux: while a break sequence runs, the break generator's level drives the line and no frames are accepted.
- Output `tx` feeds the open-drain/tristate UPDI pad driver.

Parameters:
- BIT_CLK, 10, clk cycles per UPDI bit; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled on accept.
- valid  input  1  upstream has a byte on data_in.
- ready  output  1  block can accept a byte this cycle.
- brk_busy  input  1  busy from updi_double_break; break owns the line.
- brk_line  input  1  line level (pulse) from updi_double_break.
- tx  output  1  UPDI line level; idle high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse: frame completed normally.
- abort  output  1  one-cycle pulse: frame killed by break.

Behaviour:
- Reset (async, immediate): state IDLE, tx=1 (or brk_line if brk_busy), busy=0, done=0, abort=0, counters 0, shift register 0.
- Frame format, 12 bits in order:
  - start bit = 0;
  - data[0]..data[7], LSB first;
  - even parity = XOR of data[7:0];
  - stop1 = 1;
  - stop2 = 1.
- Bit timing: each bit holds for exactly BIT_CLK cycles. Frame length is 12*BIT_CLK cycles.
- Handshake:
  - ready = (state==IDLE) && !brk_busy; combinational.
  - Accept occurs when valid && ready at a rising edge; data_in is latched and the parity is computed then.
  - valid is ignored when ready=0.
- Latency: the start bit appears on tx in the cycle after accept.
- busy is high from the cycle after accept through the last cycle of stop2.
- done:
  - Pulses high for exactly 1 cycle immediately after stop2 ends.
  - In that cycle busy=0, tx=1, state=IDLE, and ready may be 1.
  - A byte accepted in the done cycle starts its start bit on the next cycle, so back-to-back frames are separated by exactly 1 idle-high cycle.
- State machine: IDLE → START → DATA (bit index 0..7) → PARITY → STOP (index 0..1) → IDLE.
  - A bit-cycle counter runs 0..BIT_CLK-1; the state/bit advance happens when the counter reaches BIT_CLK-1.
  - The counter is $clog2(BIT_CLK) bits wide; it never overflows or wraps outside its range.
- Line mux: tx = brk_busy ? brk_line : frame level (1 when IDLE).
- Break mid-frame: if brk_busy rises while busy=1:
  - tx follows brk_line in the same cycle (combinational);
  - on the next edge: state→IDLE, busy→0, abort pulses for 1 cycle;
  - done is not pulsed and the byte is discarded.
- Simultaneous valid and brk_busy rising in IDLE: ready=0, so no accept.
- Reset mid-frame: immediate abandonment; no done and no abort pulse; tx returns to 1.
- data_in changes after accept have no effect on the frame in flight.

Test Plan:
- Reset, BIT_CLK=10:
  - tx=1, busy=0, done=0, abort=0, ready=1 while rst is held and after release (brk_busy=0).
- Send 0x55 (SYNCH):
  - tx sequence per 10-cycle bit: 0,1,0,1,0,1,0,1,0,0(parity),1,1;
  - busy high exactly 120 cycles;
  - done pulse on cycle 121 after accept.
- Send 0x01:
  - parity bit = 1;
  - bit 1 (data[0]) = 1, bits 2–8 = 0.
- Back-to-back 0xC6 then 0x80 with valid held:
  - second accept occurs in the done cycle;
  - exactly 1 idle-high cycle between stop2 and the next start bit;
  - parities 0 and 1 respectively.
- Break mid-frame:
  - assert brk_busy with brk_line=0 during data bit 3 of 0xFF;
  - tx=0 same cycle, abort pulse on the next cycle, busy=0, no done;
  - ready stays 0 until brk_busy drops.
- Async reset during the parity bit:
  - tx=1 and busy=0 without waiting for a clock edge;
  - no done/abort;
  - a new 0x55 frame after release is bit-exact.
